// File: rtl/tsn_gcl_pkg.sv
// rtl/tsn_gcl_pkg.sv - shared types and width helpers for the gate control list executor
package tsn_gcl_pkg;

  // Entry fields are sized for the widest supported build; unused upper bits stay zero.
  localparam int GCL_MAX_QUEUES = 32;
  localparam int GCL_MAX_TIME_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } gcl_state_t;

  typedef struct packed {
    logic [GCL_MAX_QUEUES-1:0] gates;
    logic [GCL_MAX_TIME_W-1:0] interval;
  } gcl_entry_t;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gcl_bank_regs.sv
// rtl/gcl_bank_regs.sv - one bank of gate control list entries, indexed write, asynchronous read
module gcl_bank_regs
  import tsn_gcl_pkg::*;
#(
  parameter int NUM_QUEUES = 8,
  parameter int LIST_DEPTH = 16,
  parameter int TIME_W     = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic [idx_width(LIST_DEPTH)-1:0]  wr_idx,
  input  logic [NUM_QUEUES-1:0]             wr_gates,
  input  logic [TIME_W-1:0]                 wr_interval,
  input  logic [idx_width(LIST_DEPTH)-1:0]  rd_idx,
  output gcl_entry_t                        rd_entry
);

  gcl_entry_t mem [LIST_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LIST_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx].gates    <= GCL_MAX_QUEUES'(wr_gates);
      mem[wr_idx].interval <= GCL_MAX_TIME_W'(wr_interval);
    end
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/gate_list_executor.sv
// rtl/gate_list_executor.sv - 802.1Qbv gate control list executor with double-buffered admin/oper lists
module gate_list_executor
  import tsn_gcl_pkg::*;
#(
  parameter int                    NUM_QUEUES    = 8,
  parameter int                    LIST_DEPTH    = 16,
  parameter int                    TIME_W        = 20,
  parameter int                    TICK_NS       = 8,
  parameter logic [NUM_QUEUES-1:0] DEFAULT_GATES = '1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cycle_start,
  input  logic                              ld_we,
  input  logic [idx_width(LIST_DEPTH)-1:0]  ld_addr,
  input  logic [NUM_QUEUES-1:0]             ld_gates,
  input  logic [TIME_W-1:0]                 ld_interval,
  input  logic                              ld_commit,
  input  logic [len_width(LIST_DEPTH)-1:0]  ld_len,
  output logic                              ld_reject,
  output logic                              config_pending,
  output logic [NUM_QUEUES-1:0]             gate_states,
  output logic [idx_width(LIST_DEPTH)-1:0]  entry_idx,
  output logic                              oper_valid,
  output logic                              cycle_overrun
);

  localparam int                IDX_W     = idx_width(LIST_DEPTH);
  localparam int                LEN_W     = len_width(LIST_DEPTH);
  localparam logic [TIME_W-1:0] TICK      = TIME_W'(TICK_NS);
  localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(LIST_DEPTH);

  gcl_state_t        state;
  logic              oper_bank;
  logic [LEN_W-1:0]  admin_len;
  logic [LEN_W-1:0]  oper_len;
  logic [TIME_W-1:0] remaining;
  logic [LEN_W-1:0]  next_count;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_bank;
  logic              wr_ok;
  logic              commit_ok;
  logic              last_tick;
  logic              last_entry;
  logic              list_done;
  gcl_entry_t        bank_rd [2];
  gcl_entry_t        cur;

  assign wr_ok      = ld_we && !config_pending;
  assign commit_ok  = !config_pending && (ld_len != '0) && (ld_len <= DEPTH_LEN);
  assign next_count = LEN_W'(entry_idx) + LEN_W'(1);
  assign last_tick  = remaining <= TICK;
  assign last_entry = next_count >= oper_len;
  assign list_done  = last_tick && last_entry;

  // Read port looks ahead: entry 0 of the (possibly just-swapped) list on a cycle boundary, else k+1.
  assign rd_idx  = cycle_start ? '0 : IDX_W'(next_count);
  assign rd_bank = (cycle_start && config_pending) ? ~oper_bank : oper_bank;
  assign cur     = bank_rd[rd_bank];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gcl_bank_regs #(
      .NUM_QUEUES (NUM_QUEUES),
      .LIST_DEPTH (LIST_DEPTH),
      .TIME_W     (TIME_W)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .we          (wr_ok && (oper_bank != 1'(b))),
      .wr_idx      (ld_addr),
      .wr_gates    (ld_gates),
      .wr_interval (ld_interval),
      .rd_idx      (rd_idx),
      .rd_entry    (bank_rd[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      oper_bank      <= 1'b0;
      admin_len      <= '0;
      oper_len       <= '0;
      remaining      <= '0;
      gate_states    <= DEFAULT_GATES;
      entry_idx      <= '0;
      oper_valid     <= 1'b0;
      config_pending <= 1'b0;
      ld_reject      <= 1'b0;
      cycle_overrun  <= 1'b0;
    end else begin
      ld_reject     <= (ld_we && config_pending) || (ld_commit && !commit_ok);
      cycle_overrun <= 1'b0;
      if (ld_commit && commit_ok) begin
        admin_len      <= ld_len;
        config_pending <= 1'b1;
      end
      if (cycle_start) begin
        if (config_pending) begin
          oper_bank      <= ~oper_bank;
          oper_len       <= admin_len;
          oper_valid     <= 1'b1;
          config_pending <= 1'b0;
        end
        if (oper_valid || config_pending) begin
          state         <= ST_RUN;
          entry_idx     <= '0;
          gate_states   <= NUM_QUEUES'(cur.gates);
          remaining     <= TIME_W'(cur.interval);
          // A list ending on exactly this clock fits the cycle and is not an overrun.
          cycle_overrun <= (state == ST_RUN) && !list_done;
        end
      end else if (state == ST_RUN) begin
        if (!last_tick) begin
          remaining <= remaining - TICK;
        end else if (!last_entry) begin
          entry_idx   <= IDX_W'(next_count);
          gate_states <= NUM_QUEUES'(cur.gates);
          remaining   <= TIME_W'(cur.interval);
        end else begin
          state <= ST_HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_list_executor.sv
// tb/tb_gate_list_executor.sv - self-checking bench for gate_list_executor against a schedule-level model
module tb_gate_list_executor;

  localparam int NQ    = 8;
  localparam int DEPTH = 16;
  localparam int TW    = 20;
  localparam int TICK  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cycle_start = 1'b0;
  logic          ld_we = 1'b0;
  logic [3:0]    ld_addr = '0;
  logic [NQ-1:0] ld_gates = '0;
  logic [TW-1:0] ld_interval = '0;
  logic          ld_commit = 1'b0;
  logic [4:0]    ld_len = '0;
  logic          ld_reject;
  logic          config_pending;
  logic [NQ-1:0] gate_states;
  logic [3:0]    entry_idx;
  logic          oper_valid;
  logic          cycle_overrun;

  always #5 clk = ~clk;

  gate_list_executor #(
    .NUM_QUEUES    (NQ),
    .LIST_DEPTH    (DEPTH),
    .TIME_W        (TW),
    .TICK_NS       (TICK),
    .DEFAULT_GATES (8'hFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cycle_start    (cycle_start),
    .ld_we          (ld_we),
    .ld_addr        (ld_addr),
    .ld_gates       (ld_gates),
    .ld_interval    (ld_interval),
    .ld_commit      (ld_commit),
    .ld_len         (ld_len),
    .ld_reject      (ld_reject),
    .config_pending (config_pending),
    .gate_states    (gate_states),
    .entry_idx      (entry_idx),
    .oper_valid     (oper_valid),
    .cycle_overrun  (cycle_overrun)
  );

  int checks = 0;
  int errors = 0;

  // Model: lists as arrays; position in the cycle is a clock count t since the boundary.
  logic [7:0] m_gates [2][DEPTH];
  int         m_int   [2][DEPTH];
  int         m_oper_bank, m_oper_len, m_admin_len, m_t;
  bit         m_valid, m_pending, e_reject, e_overrun;

  logic [7:0] seen_g [$];
  int         n_over;
  int         exp_g [3];
  int         exp_n [3];

  typedef struct {
    bit we;
    bit commit;
    int len;
    bit cs;
    bit exp_rej;
    bit exp_pend;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dur(input int iv);
    return (iv == 0) ? 1 : (iv + TICK - 1) / TICK;
  endfunction

  function automatic int list_total();
    int s = 0;
    for (int k = 0; k < m_oper_len; k++) s += dur(m_int[m_oper_bank][k]);
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < DEPTH; k++) begin
        m_gates[b][k] = '0;
        m_int[b][k]   = 0;
      end
    m_oper_bank = 0; m_oper_len = 0; m_admin_len = 0; m_t = 0;
    m_valid = 0; m_pending = 0; e_reject = 0; e_overrun = 0;
  endtask

  task automatic model_edge();
    bit was_pending = m_pending;
    e_reject  = 0;
    e_overrun = 0;
    if (ld_we) begin
      if (was_pending) e_reject = 1;
      else begin
        m_gates[1-m_oper_bank][ld_addr] = ld_gates;
        m_int[1-m_oper_bank][ld_addr]   = int'(ld_interval);
      end
    end
    if (ld_commit) begin
      if (was_pending || ld_len == 0 || int'(ld_len) > DEPTH) e_reject = 1;
      else begin
        m_admin_len = int'(ld_len);
        m_pending   = 1;
      end
    end
    if (cycle_start) begin
      if (m_valid && m_t < list_total() - 1) e_overrun = 1;
      if (was_pending) begin
        m_oper_bank = 1 - m_oper_bank;
        m_oper_len  = m_admin_len;
        m_valid     = 1;
        m_pending   = 0;
      end
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_all();
    int acc = 0;
    int idx = 0;
    int g   = 8'hFF;
    if (m_valid) begin
      idx = m_oper_len - 1;
      for (int k = 0; k < m_oper_len; k++) begin
        acc += dur(m_int[m_oper_bank][k]);
        if (m_t < acc) begin
          idx = k;
          break;
        end
      end
      g = int'(m_gates[m_oper_bank][idx]);
    end
    chk("gate_states", int'(gate_states), g);
    chk("entry_idx", int'(entry_idx), idx);
    chk("oper_valid", int'(oper_valid), int'(m_valid));
    chk("config_pending", int'(config_pending), int'(m_pending));
    chk("ld_reject", int'(ld_reject), int'(e_reject));
    chk("cycle_overrun", int'(cycle_overrun), int'(e_overrun));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    cycle_start = 1'b0;
    ld_we       = 1'b0;
    ld_commit   = 1'b0;
  endtask

  task automatic write_entry(input int a, input int g, input int iv);
    ld_we = 1'b1; ld_addr = 4'(a); ld_gates = 8'(g); ld_interval = 20'(iv);
    tick();
  endtask

  task automatic commit(input int len);
    ld_commit = 1'b1; ld_len = 5'(len);
    tick();
  endtask

  task automatic run_cycle(input int period);
    seen_g = {};
    cycle_start = 1'b1;
    for (int i = 0; i < period; i++) begin
      tick();
      seen_g.push_back(gate_states);
      if (cycle_overrun) n_over++;
    end
  endtask

  task automatic check_runs(input string nm, input int nr);
    int rg [$];
    int rn [$];
    foreach (seen_g[i]) begin
      if (rg.size() == 0 || rg[rg.size()-1] != int'(seen_g[i])) begin
        rg.push_back(int'(seen_g[i]));
        rn.push_back(1);
      end else begin
        rn[rn.size()-1] = rn[rn.size()-1] + 1;
      end
    end
    chk($sformatf("%s_runs", nm), rg.size(), nr);
    for (int k = 0; k < nr; k++) begin
      chk($sformatf("%s_gate%0d", nm, k), (k < rg.size()) ? rg[k] : -1, exp_g[k]);
      chk($sformatf("%s_len%0d", nm, k), (k < rn.size()) ? rn[k] : -1, exp_n[k]);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1, 0,  0, 1, 0};
    tbl[1] = '{0, 1, 17, 0, 1, 0};
    tbl[2] = '{0, 1, 3,  0, 0, 1};
    tbl[3] = '{1, 0, 0,  0, 1, 1};
    tbl[4] = '{0, 1, 3,  0, 1, 1};
    tbl[5] = '{1, 0, 0,  1, 1, 0};
    tbl[6] = '{1, 0, 0,  0, 0, 0};
    tbl[7] = '{0, 1, 2,  1, 0, 1};
    tbl[8] = '{0, 0, 0,  0, 0, 1};

    #1 rst = 1'b0;
    #2;
    chk("rst_gates", int'(gate_states), 8'hFF);
    chk("rst_idx", int'(entry_idx), 0);
    chk("rst_valid", int'(oper_valid), 0);
    chk("rst_pending", int'(config_pending), 0);
    chk("rst_reject", int'(ld_reject), 0);
    chk("rst_overrun", int'(cycle_overrun), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // No list committed: stays idle with default gates.
    run_cycle(2048);
    run_cycle(2048);
    chk("idle_valid", int'(oper_valid), 0);
    chk("idle_gates", int'(gate_states), 8'hFF);

    // Three-entry list that exactly fills a 2048-clock cycle.
    write_entry(0, 8'h00, 20'h35B0);
    write_entry(1, 8'h01, 20'h0D0);
    write_entry(2, 8'h02, 20'h980);
    commit(3);
    n_over = 0;
    exp_g = '{8'h00, 8'h01, 8'h02};
    exp_n = '{1718, 26, 304};
    run_cycle(2048);
    check_runs("full_a", 3);
    run_cycle(2048);
    check_runs("full_b", 3);
    chk("full_overrun", n_over, 0);

    // Shorter cycle truncates entry 2.
    n_over = 0;
    exp_n = '{1718, 26, 56};
    run_cycle(1800);
    run_cycle(1800);
    check_runs("trunc", 3);
    run_cycle(1800);
    chk("trunc_overrun", n_over, 2);

    // Two-entry list holds the last entry until the boundary.
    write_entry(0, 8'h00, 20'h35B0);
    write_entry(1, 8'h01, 20'h0D0);
    commit(2);
    exp_n = '{1718, 330, 0};
    run_cycle(2048);
    check_runs("hold_a", 2);
    run_cycle(2048);
    check_runs("hold_b", 2);

    // Hitless swap: list B committed mid-cycle only takes over at the next boundary.
    write_entry(0, 8'h00, 20'h35B0);
    write_entry(1, 8'h01, 20'h0D0);
    write_entry(2, 8'h02, 20'h980);
    commit(3);
    run_cycle(2048);
    cycle_start = 1'b1;
    tick();
    repeat (499) tick();
    for (int a = 0; a < DEPTH; a++) write_entry(a, 8'hF0, 20'h800);
    commit(16);
    chk("swap_pending", int'(config_pending), 1);
    repeat (2048 - 517) tick();
    chk("swap_a_last_gates", int'(gate_states), 8'h02);
    chk("swap_a_last_idx", int'(entry_idx), 2);
    chk("swap_pending_end", int'(config_pending), 1);
    cycle_start = 1'b1;
    tick();
    chk("swap_b_gates", int'(gate_states), 8'hF0);
    chk("swap_b_pending", int'(config_pending), 0);
    repeat (255) tick();
    chk("swap_b_idx0", int'(entry_idx), 0);
    tick();
    chk("swap_b_idx1", int'(entry_idx), 1);

    // Write/commit refusal sequences.
    for (int i = 0; i < 9; i++) begin
      ld_we = tbl[i].we; ld_addr = 4'd15; ld_gates = 8'h5A; ld_interval = 20'd40;
      ld_commit = tbl[i].commit; ld_len = 5'(tbl[i].len); cycle_start = tbl[i].cs;
      tick();
      chk($sformatf("tbl%0d_reject", i), int'(ld_reject), int'(tbl[i].exp_rej));
      chk($sformatf("tbl%0d_pending", i), int'(config_pending), int'(tbl[i].exp_pend));
    end

    // Asynchronous reset mid-run drops the pending commit and the oper list.
    repeat (100) tick();
    #1 rst = 1'b0;
    #1;
    chk("midrst_gates", int'(gate_states), 8'hFF);
    chk("midrst_idx", int'(entry_idx), 0);
    chk("midrst_valid", int'(oper_valid), 0);
    chk("midrst_pending", int'(config_pending), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_cycle(64);
    run_cycle(64);
    chk("postrst_valid", int'(oper_valid), 0);
    chk("postrst_gates", int'(gate_states), 8'hFF);

    // Random writes, commits and cycle lengths against the model.
    for (int r = 0; r < 300; r++) begin
      int per = $urandom_range(6, 60);
      cycle_start = 1'b1;
      for (int i = 0; i < per; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          ld_we = 1'b1; ld_addr = 4'($urandom); ld_gates = 8'($urandom);
          ld_interval = 20'($urandom_range(0, 100));
        end
        if ($urandom_range(0, 29) == 0) begin
          ld_commit = 1'b1; ld_len = 5'($urandom_range(0, 17));
        end
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
